conv_window_shifter: RTL
========================

// Module: conv_window_shifter
// PURPOSE
//  Parametrised successor of the data-router register array. Loads one input row (BUFW words)
//  from the on-chip buffer or the reuse FIFO by valid/ready handshake, then streams KSIZE-column
//  windows to the POX-wide PE array, one kernel column per beat, with runtime stride (1/2) and
//  runtime kernel size. Sits between the buffer/FIFO read ports and the PE array input.
// PARAMETERS
//  DW         32  data word width
//  POX        16  PE lanes (output pixels per row segment)
//  KSIZE      3   maximum kernel width; runtime i_ksize is 1..KSIZE
//  MAX_STRIDE 2   maximum stride; runtime i_stride is 1..MAX_STRIDE
//  BUFW       34  row words; elaboration check BUFW >= (POX-1)*MAX_STRIDE+KSIZE
//  KW         $clog2(KSIZE+1) kernel-index width (derived localparam)
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          async active-low reset
//  i_start      in   1          pulse: begin one row job with cfg below
//  i_src_sel    in   1          0 = buffer, 1 = FIFO
//  i_stride     in   2          1 or 2
//  i_ksize      in   KW         1..KSIZE
//  i_buf_valid  in   1          buffer row valid
//  i_buf_data   in   DW*BUFW    buffer row (unpacked [BUFW])
//  o_buf_ready  out  1          row accepted from buffer this cycle if valid
//  i_fifo_valid in   1          FIFO row valid
//  i_fifo_data  in   DW*BUFW    FIFO row (unpacked [BUFW])
//  o_fifo_ready out  1          row accepted from FIFO this cycle if valid
//  o_pe_valid   out  1          window beat valid
//  i_pe_ready   in   1          PE array accepts beat
//  o_pe_data    out  DW*POX     lane p = mem[p*stride] (unpacked [POX])
//  o_pe_kidx    out  KW         kernel column of current beat, 0..ksize-1
//  o_pe_last    out  1          current beat is column ksize-1
//  o_busy       out  1          state != IDLE
//  o_cfg_err    out  1          one-cycle pulse: i_start with illegal cfg
// BEHAVIOUR
//  Reset: state IDLE, mem all zero, kidx 0, all outputs 0 (ready, valid, last, busy, err = 0).
//  FSM IDLE -> WAIT_SRC -> STREAM -> (IDLE | WAIT_SRC).
//  IDLE: i_start with legal cfg latches stride/ksize/src, -> WAIT_SRC. Illegal cfg (stride 0 or
//   >MAX_STRIDE, ksize 0 or >KSIZE): o_cfg_err=1 next cycle, stay IDLE. i_start ignored when busy
//   except as below.
//  WAIT_SRC: only the selected source's ready is 1 (combinational from state+src; never both).
//   On selected valid&&ready: mem <= row, kidx <= 0, -> STREAM. Unselected source ignored.
//  STREAM: o_pe_valid=1; o_pe_data lane p = mem[p*stride_q] (stride mux, combinational from regs).
//   Latency: row accepted in cycle N -> first beat valid in N+1. Data/kidx held stable while
//   i_pe_ready=0. On valid&&ready with kidx<ksize-1: mem[i] <= mem[i+1] for i<BUFW-1,
//   mem[BUFW-1] <= 0, kidx++. On last beat accepted: -> IDLE, or -> WAIT_SRC if i_start is high
//   in that same cycle with legal cfg (new cfg latched, zero-bubble back-to-back). Illegal cfg
//   in that cycle: o_cfg_err pulse, -> IDLE.
//  ksize=1: single beat, o_pe_last=1 on it. o_pe_last = (state==STREAM)&&(kidx==ksize_q-1).
//  Lane index p*stride+kidx always < BUFW by the BUFW parameter check; no wrap-around.
//  Async reset mid-job aborts immediately; partial row discarded, no beats emitted afterwards.
// STRUCTURE
//  Package data_router_pkg: state enum {IDLE, WAIT_SRC, STREAM}, src enum {SRC_BUF, SRC_FIFO},
//   constants STRIDE_MIN=1, KSIZE_MIN=1, function cfg_legal(stride,ksize).
//  One sub-module: window_stride_mux (mem[BUFW] + stride -> POX lanes, pure combinational).
//  Top holds FSM, mem register file, kidx counter, handshake logic.
// TESTING
//  1 Buffer, stride1, ksize3, row mem[i]=i, pe_ready=1 -> 3 beats, lane p = p, p+1, p+2; last on beat 3.
//  2 FIFO, stride2, ksize3, row=100+i -> lane p = 100+2p, +1, +2; o_buf_ready stays 0 throughout.
//  3 Backpressure: pe_ready low 4 cycles on beat 2 -> data/kidx=1 held, total beats still 3.
//  4 i_start with stride=3 or ksize=0 -> o_cfg_err single pulse, busy=0, no ready asserted.
//  5 Back-to-back: i_start on last-beat handshake -> WAIT_SRC next cycle, zero idle cycle, new stride used.
//  6 rst_n low mid-STREAM at kidx=1 -> all outputs 0 asynchronously; after release idle, mem zero.

Source files
------------

// File: rtl/data_router_pkg.sv
// Shared types and configuration checks for the window-shifting data router.
package data_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SRC,
    STREAM
  } state_e;

  typedef enum logic {
    SRC_BUF,
    SRC_FIFO
  } src_e;

  localparam int unsigned STRIDE_MIN = 1;
  localparam int unsigned KSIZE_MIN  = 1;

  // A row job is only accepted when both stride and kernel size are inside their ranges.
  function automatic logic cfg_legal(input int unsigned stride,
                                     input int unsigned ksize,
                                     input int unsigned max_stride,
                                     input int unsigned max_ksize);
    return (stride >= STRIDE_MIN) && (stride <= max_stride) &&
           (ksize >= KSIZE_MIN) && (ksize <= max_ksize);
  endfunction

endpackage

// File: rtl/window_stride_mux.sv
// Selects POX lanes out of the row register file: lane p takes word p*stride.
module window_stride_mux #(
  parameter int unsigned DW         = 32,
  parameter int unsigned POX        = 16,
  parameter int unsigned MAX_STRIDE = 2,
  parameter int unsigned BUFW       = 34
) (
  input  logic [DW-1:0] mem [BUFW],
  input  logic [1:0]    stride,
  output logic [DW-1:0] lanes [POX]
);

  // Stride mux; an out-of-range stride code yields zero lanes.
  always_comb begin
    for (int unsigned p = 0; p < POX; p++) begin
      lanes[p] = '0;
      for (int unsigned s = 1; s <= MAX_STRIDE; s++) begin
        if (stride == 2'(s)) begin
          lanes[p] = mem[p * s];
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_shifter.sv
// Loads one row from buffer or reuse FIFO, then streams KSIZE kernel-column windows
// to the PE array by shifting the row register file one word per accepted beat.
module conv_window_shifter
  import data_router_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned POX        = 16,
  parameter int unsigned KSIZE      = 3,
  parameter int unsigned MAX_STRIDE = 2,
  parameter int unsigned BUFW       = 34,
  localparam int unsigned KW        = $clog2(KSIZE + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_src_sel,
  input  logic [1:0]    i_stride,
  input  logic [KW-1:0] i_ksize,
  input  logic          i_buf_valid,
  input  logic [DW-1:0] i_buf_data [BUFW],
  output logic          o_buf_ready,
  input  logic          i_fifo_valid,
  input  logic [DW-1:0] i_fifo_data [BUFW],
  output logic          o_fifo_ready,
  output logic          o_pe_valid,
  input  logic          i_pe_ready,
  output logic [DW-1:0] o_pe_data [POX],
  output logic [KW-1:0] o_pe_kidx,
  output logic          o_pe_last,
  output logic          o_busy,
  output logic          o_cfg_err
);

  if (BUFW < (POX - 1) * MAX_STRIDE + KSIZE) begin : g_bufw_check
    $error("BUFW too small for POX, MAX_STRIDE and KSIZE");
  end

  state_e        state;
  state_e        state_nxt;
  src_e          src_q;
  logic [1:0]    stride_q;
  logic [KW-1:0] ksize_q;
  logic [KW-1:0] kidx;
  logic          err_q;
  logic [DW-1:0] mem [BUFW];

  logic cfg_ok;
  logic src_valid;
  logic row_take;
  logic beat_take;
  logic at_last;
  logic job_done;
  logic start_window;
  logic start_ok;
  logic start_bad;

  assign cfg_ok       = cfg_legal(32'(i_stride), 32'(i_ksize), MAX_STRIDE, KSIZE);
  assign src_valid    = (src_q == SRC_FIFO) ? i_fifo_valid : i_buf_valid;
  assign row_take     = (state == WAIT_SRC) && src_valid;
  assign beat_take    = (state == STREAM) && i_pe_ready;
  assign at_last      = (kidx == ksize_q - KW'(1));
  assign job_done     = beat_take && at_last;
  // A new job may start from IDLE or on the very cycle the last beat is accepted.
  assign start_window = (state == IDLE) || job_done;
  assign start_ok     = start_window && i_start && cfg_ok;
  assign start_bad    = start_window && i_start && !cfg_ok;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start_ok) state_nxt = WAIT_SRC;
      WAIT_SRC: if (row_take) state_nxt = STREAM;
      STREAM:   if (job_done) state_nxt = start_ok ? WAIT_SRC : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from the current state.
  always_comb begin
    o_buf_ready  = (state == WAIT_SRC) && (src_q == SRC_BUF);
    o_fifo_ready = (state == WAIT_SRC) && (src_q == SRC_FIFO);
    o_pe_valid   = (state == STREAM);
    o_pe_last    = (state == STREAM) && at_last;
    o_busy       = (state != IDLE);
    o_pe_kidx    = kidx;
    o_cfg_err    = err_q;
  end

  // Job configuration, error pulse, row register file and kernel-column counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= SRC_BUF;
      stride_q <= '0;
      ksize_q  <= '0;
      kidx     <= '0;
      err_q    <= 1'b0;
      mem      <= '{default: '0};
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        src_q    <= i_src_sel ? SRC_FIFO : SRC_BUF;
        stride_q <= i_stride;
        ksize_q  <= i_ksize;
      end
      if (row_take) begin
        kidx <= '0;
        for (int unsigned i = 0; i < BUFW; i++) begin
          mem[i] <= (src_q == SRC_FIFO) ? i_fifo_data[i] : i_buf_data[i];
        end
      end else if (beat_take && !at_last) begin
        // Shifting the row left by one word moves kernel column kidx+1 under the stride mux.
        kidx <= kidx + KW'(1);
        for (int unsigned i = 0; i < BUFW - 1; i++) begin
          mem[i] <= mem[i + 1];
        end
        mem[BUFW-1] <= '0;
      end
    end
  end

  window_stride_mux #(
    .DW        (DW),
    .POX       (POX),
    .MAX_STRIDE(MAX_STRIDE),
    .BUFW      (BUFW)
  ) u_mux (
    .mem   (mem),
    .stride(stride_q),
    .lanes (o_pe_data)
  );

endmodule
